// File: rtl/exu_alu_sched_if.sv
// Requester/ALU/response bundle for the shared exu ALU issue scheduler.
// The master side belongs to the requesters and ALU; the scheduler is the slave.
interface exu_alu_sched_if #(
  parameter int NREQ = 2,
  parameter int TAGW = 4,
  parameter int SELW = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      req_ready;
  logic [SELW-1:0]      alu_sel;
  logic                 alu_valid;
  logic                 alu_enable;
  logic                 alu_flush_upper;
  logic [NREQ-1:0]      rsp_valid;
  logic [TAGW-1:0]      rsp_tag;
  logic                 rsp_misp;

  modport master (
    output req_valid, req_tag, alu_flush_upper,
    input  req_ready, alu_sel, alu_valid, alu_enable, rsp_valid, rsp_tag, rsp_misp
  );

  modport slave (
    input  req_valid, req_tag, alu_flush_upper,
    output req_ready, alu_sel, alu_valid, alu_enable, rsp_valid, rsp_tag, rsp_misp
  );
endinterface

// File: rtl/exu_alu_sched.sv
// Round-robin issue scheduler sharing one ALU pipe among NREQ requesters,
// with one-deep E1 tracking, tagged responses and a post-flush_upper refill bubble.
//
// state | meaning
// IDLE  | no op in flight in E1
// RUN   | E1 op in flight, responds this cycle unless frozen/flushed
// REDIR | refill bubble after flush_upper, counting r_cnt down to 0
module exu_alu_sched #(
  parameter int NREQ      = 2,
  parameter int TAGW      = 4,
  parameter int REDIR_CYC = 2,
  parameter int SELW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  logic flush,
  output logic busy,
  exu_alu_sched_if.slave bus
);

  if (REDIR_CYC < 1 || REDIR_CYC > 15) begin : g_chk_redir
    $error("exu_alu_sched: REDIR_CYC must be in 1..15");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("exu_alu_sched: NREQ must be in 2..8");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIR} state_t;

  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_ptr, w_ptr_nxt;
  logic            r_e1_valid, w_e1_valid_nxt;
  logic [SELW-1:0] r_e1_owner, w_e1_owner_nxt;
  logic [TAGW-1:0] r_e1_tag, w_e1_tag_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;

  logic            w_redir;
  logic            w_grant_ok;
  logic            w_found;
  logic            w_gnt;
  logic [SELW-1:0] w_gnt_idx;
  logic            w_rsp;
  int              w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_e1_valid <= 1'b0;
      r_e1_owner <= '0;
      r_e1_tag   <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_e1_valid <= w_e1_valid_nxt;
      r_e1_owner <= w_e1_owner_nxt;
      r_e1_tag   <= w_e1_tag_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Round-robin search: first valid requester at or after r_ptr, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = SELW'(w_idx);
      end
    end
  end

  assign w_redir    = r_e1_valid & bus.alu_flush_upper & ~flush & ~freeze & ~rst;
  assign w_grant_ok = (r_state != S_REDIR) & ~freeze & ~flush & ~rst & ~w_redir;
  assign w_gnt      = w_grant_ok & w_found;
  assign w_rsp      = r_e1_valid & ~freeze & ~flush & ~rst;

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_e1_valid_nxt = r_e1_valid;
    w_e1_owner_nxt = r_e1_owner;
    w_e1_tag_nxt   = r_e1_tag;
    w_cnt_nxt      = r_cnt;
    if (flush) begin
      w_state_nxt    = S_IDLE;
      w_e1_valid_nxt = 1'b0;
      w_cnt_nxt      = '0;
    end else if (!freeze) begin
      if (w_redir) begin
        w_state_nxt    = S_REDIR;
        w_e1_valid_nxt = 1'b0;
        w_cnt_nxt      = 4'(REDIR_CYC - 1);
      end else if (r_state == S_REDIR) begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 4'd1;
      end else if (w_gnt) begin
        w_state_nxt    = S_RUN;
        w_e1_valid_nxt = 1'b1;
        w_e1_owner_nxt = w_gnt_idx;
        w_e1_tag_nxt   = bus.req_tag[int'(w_gnt_idx)*TAGW +: TAGW];
        w_ptr_nxt      = (w_gnt_idx == SELW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        w_state_nxt    = S_IDLE;
        w_e1_valid_nxt = 1'b0;
      end
    end
  end

  assign bus.req_ready  = w_gnt ? (NREQ'(1) << w_gnt_idx) : '0;
  assign bus.alu_sel    = w_gnt ? w_gnt_idx : '0;
  assign bus.alu_valid  = w_gnt;
  assign bus.alu_enable = w_gnt;
  assign bus.rsp_valid  = w_rsp ? (NREQ'(1) << r_e1_owner) : '0;
  assign bus.rsp_tag    = w_rsp ? r_e1_tag : '0;
  assign bus.rsp_misp   = w_rsp & bus.alu_flush_upper;
  assign busy           = ~rst & (r_e1_valid | (r_state == S_REDIR));

endmodule

// File: tb/tb_exu_alu_sched.sv
// Self-checking bench for exu_alu_sched: directed vector table for the
// corner sequences, then randomized traffic against a cycle-level reference model.
module tb_exu_alu_sched;
  localparam int NREQ = 2;
  localparam int TAGW = 4;
  localparam int RC   = 2;

  logic clk = 1'b0;
  logic rst, freeze, flush, busy;

  exu_alu_sched_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  exu_alu_sched #(.NREQ(NREQ), .TAGW(TAGW), .REDIR_CYC(RC)) dut (
    .clk   (clk),
    .rst   (rst),
    .freeze(freeze),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, frz, fl, afu;
    logic [1:0] rv;
    logic [7:0] tag;
    logic [1:0] rdy;
    logic [1:0] rsp;
    logic [3:0] rtag;
    logic       misp, busy;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model: what is in flight, where the pointer is, bubble cycles left
  int         m_ptr, m_owner, m_bub, m_g;
  bit         m_v, m_misp;
  logic [3:0] m_tag;
  logic [12:0] m_exp;

  function automatic logic [12:0] pack_out();
    return {bus.req_ready, bus.alu_sel, bus.alu_valid, bus.alu_enable,
            bus.rsp_valid, bus.rsp_tag, bus.rsp_misp, busy};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy/sel/av/en/rsp/tag/misp/busy=%b want %b", name, act, exp);
    end
  endtask

  function automatic void model_eval();
    logic [1:0] rdy, rsp;
    logic [3:0] rt;
    logic       mi, av, bz;
    rdy = '0; rsp = '0; rt = '0; mi = 1'b0; av = 1'b0; bz = 1'b0;
    m_g = -1; m_misp = 1'b0;
    if (!rst) begin
      m_misp = m_v && bus.alu_flush_upper && !flush && !freeze;
      if (m_v && !freeze && !flush) begin
        rsp = 2'(1 << m_owner); rt = m_tag; mi = bus.alu_flush_upper;
      end
      if (m_bub == 0 && !freeze && !flush && !m_misp)
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (bus.req_valid[j] && m_g < 0) m_g = j;
        end
      if (m_g >= 0) begin rdy = 2'(1 << m_g); av = 1'b1; end
      bz = m_v || (m_bub > 0);
    end
    m_exp = {rdy, (m_g == 1) ? 1'b1 : 1'b0, av, av, rsp, rt, mi, bz};
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_ptr = 0; m_v = 0; m_owner = 0; m_tag = '0; m_bub = 0;
    end else if (flush) begin
      m_v = 0; m_bub = 0;
    end else if (!freeze) begin
      if (m_misp) begin
        m_v = 0; m_bub = RC;
      end else begin
        if (m_bub > 0) m_bub--;
        m_v = (m_g >= 0);
        if (m_g >= 0) begin
          m_owner = m_g;
          m_tag   = bus.req_tag[m_g*TAGW +: TAGW];
          m_ptr   = (m_g + 1) % NREQ;
        end
      end
    end
  endfunction

  task automatic drive(input logic r, input logic fz, input logic fl, input logic afu,
                       input logic [1:0] rv, input logic [7:0] tag);
    @(negedge clk);
    rst = r; freeze = fz; flush = fl;
    bus.alu_flush_upper = afu; bus.req_valid = rv; bus.req_tag = tag;
    #1;
    model_eval();
  endtask

  function automatic void add(input logic r, input logic fz, input logic fl, input logic afu,
                              input logic [1:0] rv, input logic [7:0] tag,
                              input logic [1:0] rdy, input logic [1:0] rsp,
                              input logic [3:0] rtag, input logic misp, input logic bz);
    vec_t v;
    v.rst = r; v.frz = fz; v.fl = fl; v.afu = afu; v.rv = rv; v.tag = tag;
    v.rdy = rdy; v.rsp = rsp; v.rtag = rtag; v.misp = misp; v.busy = bz;
    tv.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    bus.alu_flush_upper = 1'b0; bus.req_valid = '0; bus.req_tag = '0;
    m_ptr = 0; m_v = 0; m_owner = 0; m_tag = '0; m_bub = 0; m_g = -1; m_misp = 0;

    //   rst frz fl afu rv     tag     rdy    rsp    rtag  misp busy
    add(1, 0, 0, 0, 2'b11, 8'h00, 2'b00, 2'b00, 4'h0, 0, 0);
    add(0, 0, 0, 0, 2'b11, 8'h53, 2'b01, 2'b00, 4'h0, 0, 0);
    add(0, 0, 0, 0, 2'b11, 8'h64, 2'b10, 2'b01, 4'h3, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'h78, 2'b01, 2'b10, 4'h6, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'h92, 2'b10, 2'b01, 4'h8, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'hBC, 2'b01, 2'b10, 4'h9, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'hDE, 2'b10, 2'b01, 4'hC, 0, 1);
    add(0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b10, 4'hD, 0, 1);
    add(0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00, 4'h0, 0, 0);
    // lone requester 1
    add(0, 0, 0, 0, 2'b10, 8'hA0, 2'b10, 2'b00, 4'h0, 0, 0);
    add(0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b10, 4'hA, 0, 1);
    // flush_upper -> REDIR_CYC bubble
    add(0, 0, 0, 0, 2'b01, 8'h05, 2'b01, 2'b00, 4'h0, 0, 0);
    add(0, 0, 0, 1, 2'b11, 8'h00, 2'b00, 2'b01, 4'h5, 1, 1);
    add(0, 0, 0, 0, 2'b11, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'h34, 2'b10, 2'b00, 4'h0, 0, 0);
    // flush beats flush_upper
    add(0, 0, 1, 1, 2'b11, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'h21, 2'b01, 2'b00, 4'h0, 0, 0);
    // freeze holds E1 and pointer
    add(0, 1, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    add(0, 1, 0, 1, 2'b00, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    add(0, 1, 0, 0, 2'b11, 8'h00, 2'b00, 2'b00, 4'h0, 0, 1);
    add(0, 0, 0, 0, 2'b11, 8'hFE, 2'b10, 2'b01, 4'h1, 0, 1);
    add(0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b10, 4'hF, 0, 1);
    add(0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00, 4'h0, 0, 0);
    // reset while in REDIR
    add(0, 0, 0, 0, 2'b10, 8'h70, 2'b10, 2'b00, 4'h0, 0, 0);
    add(0, 0, 0, 1, 2'b00, 8'h00, 2'b00, 2'b10, 4'h7, 1, 1);
    add(1, 0, 0, 0, 2'b11, 8'hFF, 2'b00, 2'b00, 4'h0, 0, 0);
    add(0, 0, 0, 0, 2'b11, 8'h39, 2'b01, 2'b00, 4'h0, 0, 0);
    add(0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b01, 4'h9, 0, 1);
    // flush_upper with nothing in flight is ignored
    add(0, 0, 0, 1, 2'b00, 8'h00, 2'b00, 2'b00, 4'h0, 0, 0);

    foreach (tv[i]) begin
      logic [12:0] exp;
      drive(tv[i].rst, tv[i].frz, tv[i].fl, tv[i].afu, tv[i].rv, tv[i].tag);
      exp = {tv[i].rdy, tv[i].rdy[1], |tv[i].rdy, |tv[i].rdy,
             tv[i].rsp, tv[i].rtag, tv[i].misp, tv[i].busy};
      chk($sformatf("dir%0d", i), pack_out(), exp);
      @(posedge clk);
      model_step();
    end

    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 25),
            2'($urandom_range(0, 3)), 8'($urandom));
      chk($sformatf("rnd%0d", c), pack_out(), m_exp);
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/exu_alu_sched.md
Name: exu_alu_sched

Overview:
- Issue scheduler that shares one exu ALU pipe between NREQ requesters (e.g. primary decode issue and a secondary/replay port).
- Grants at most one request per cycle using round-robin and drives the ALU operand-select, valid and enable controls.
- Tracks the one-deep in-flight ALU stage and returns a tagged response to the owning requester.
- Sequences the pipeline-refill bubble after an ALU branch flush (flush_upper).

Parameters:
NREQ, 2, number of requesters (2..8)
TAGW, 4, width of per-request tag returned with response
REDIR_CYC, 2, grant-blocking bubble cycles after an ALU flush_upper (1..15)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
freeze  in  1  pipeline freeze; holds all state
flush  in  1  lower pipeline flush; kills in-flight and pending grant
req_valid  in  NREQ  request valid per requester
req_tag  in  NREQ*TAGW  per-requester tag, requester i at [i*TAGW +: TAGW]
req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
alu_sel  out  max(1,$clog2(NREQ))  operand mux select = granted requester index
alu_valid  out  1  ALU valid (= any grant this cycle)
alu_enable  out  1  ALU operand flop enable (= alu_valid)
alu_flush_upper  in  1  ALU branch flush, meaningful only for the in-flight op
rsp_valid  out  NREQ  one-hot response to owner of completing op
rsp_tag  out  TAGW  tag of completing op
rsp_misp  out  1  completing op caused alu_flush_upper
busy  out  1  in-flight op present or redirect bubble active

Behaviour:
- States: IDLE (no op in flight), RUN (E1 op in flight), REDIR (bubble counting down).
- Grant eligible when: state != REDIR, ~freeze, ~flush, ~rst. At most one req_ready bit high; combinational from req_valid and pointer.
- Round-robin: search order starts at ptr, ascending, wraps mod NREQ. On a grant to i, ptr <= (i+1) mod NREQ. ptr is unchanged when there is no grant.
- Starvation bound: a continuously valid requester is granted within NREQ grant cycles.
- Grant cycle (E0): alu_sel = i, alu_valid = alu_enable = 1.
  - Next cycle (if ~freeze): e1_valid <= 1, e1_owner <= i, e1_tag <= req_tag[i].
  - Latency: 1 cycle from grant to response.
- E1 response: rsp_valid[e1_owner] = e1_valid & ~freeze & ~flush; rsp_tag = e1_tag (0 when no response); rsp_misp = rsp_valid-any & alu_flush_upper.
- Back-to-back: grants every cycle are legal in RUN. E1 is replaced by the new grant on the same edge. Throughput is 1/cycle.
- Redirect: on e1_valid & alu_flush_upper & ~flush & ~freeze:
  - The same-cycle grant is suppressed (req_ready all 0).
  - e1_valid <= 0, state <= REDIR, cnt <= REDIR_CYC-1.
  - In REDIR: no grants. cnt decrements each ~freeze cycle. At cnt==0 go to IDLE on the next edge, so exactly REDIR_CYC grant-free cycles follow the misp cycle.
- Flush (highest priority):
  - No grant that cycle, no response that cycle.
  - Next state: e1_valid = 0, state = IDLE, cnt = 0. ptr is unchanged.
  - Flush coincident with alu_flush_upper: flush wins and no REDIR is entered.
- Freeze:
  - All flops hold (ptr, e1, state, cnt). No grants; rsp_valid = 0.
  - The held E1 op responds in the first unfrozen cycle.
  - alu_flush_upper is ignored while frozen.
- alu_flush_upper with e1_valid = 0 is ignored.
- busy = e1_valid | (state == REDIR).
- Reset (sync, rst sampled high at edge):
  - ptr = 0, state = IDLE, e1_valid = 0, e1_owner = 0, e1_tag = 0, cnt = 0.
  - While rst is high, all outputs are forced 0: req_ready, alu_valid, alu_enable, rsp_valid, rsp_tag, rsp_misp, busy.
  - rst mid-operation drops the in-flight op with no response.
- Tag width: no arithmetic. Counter width is 4 bits; the REDIR_CYC range is asserted at elaboration.

Test Plan:
- NREQ=2, req_valid=2'b11 held 6 cycles from reset -> req_ready sequence 01,10,01,10,01,10. rsp_valid follows 1 cycle later with matching tags.
- Single requester 1 valid with tag=4'hA, ptr=0 -> req_ready=2'b10, alu_sel=1 same cycle. Next cycle rsp_valid=2'b10, rsp_tag=4'hA.
- Grant at cycle t, alu_flush_upper=1 at t+1 -> rsp_misp=1 at t+1. With REDIR_CYC=2, req_ready=0 at t+1, t+2, t+3. Grants resume at t+4; busy=1 for t+1..t+3.
- flush=1 in the same cycle as e1 completion and alu_flush_upper -> rsp_valid=0, no REDIR, and a grant is allowed the next cycle.
- freeze=1 for 3 cycles with an op in E1 -> rsp_valid=0 during freeze, then one response with the original tag in the first unfrozen cycle, and ptr is unchanged.
- rst asserted while in REDIR with cnt=1 -> the next cycle is IDLE, all outputs are 0 during rst, and the first grant after release goes to requester 0.
